// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
//
// Write-back stage feeding the register file. Merges single-cycle ALU results
// and variable-latency load results (buffered in a DEPTH-entry FIFO) into at
// most one register write per cycle. Handles write-after-write ordering by
// killing queued loads that a younger ALU write overtakes. Exports a mask of
// registers with a live queued load for the hazard unit.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   aluValid/aluReg/aluData    ALU result input
//   aluReady                   ALU result accepted (combinational)
//   memValid/memReg/memData    load result input
//   memReady                   load result accepted (combinational)
//   writeEnable/writeReg/
//   writeData                  registered register-file write port
//   pendingMask                registered mask of registers with live loads
//
// Optional feature macro: WB_BYPASS_EN
//   When defined, a load accepted into an idle block (FIFO empty, no ALU
//   result accepted) is written directly on the same edge.
// -----------------------------------------------------------------------------
module writeback_arbiter #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        aluValid,
   input  logic [4:0]  aluReg,
   input  logic [31:0] aluData,
   output logic        aluReady,
   input  logic        memValid,
   input  logic [4:0]  memReg,
   input  logic [31:0] memData,
   output logic        memReady,
   output logic        writeEnable,
   output logic [4:0]  writeReg,
   output logic [31:0] writeData,
   output logic [31:0] pendingMask
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   // FIFO storage and bookkeeping
   logic [4:0]       reg_mem_r  [DEPTH];
   logic [31:0]      data_mem_r [DEPTH];
   logic [DEPTH-1:0] kill_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW-1:0]    wr_ptr_r;
   logic [AW:0]      count_r;

   // Handshake and control
   logic             full_s;
   logic             empty_s;
   logic             ready_s;
   logic             mem_acc_s;
   logic             alu_acc_s;
   logic             alu_wr_s;
   logic             bypass_s;
   logic             push_s;
   logic             pop_s;

   // Next write-port values
   logic             wr_en_s;
   logic [4:0]       wr_reg_s;
   logic [31:0]      wr_data_s;

   // Post-update FIFO view used to build pendingMask
   logic [DEPTH-1:0] kill_nxt_s;
   logic [AW-1:0]    rd_nxt_s;
   logic [AW:0]      count_nxt_s;
   logic [4:0]       slot_reg_s [DEPTH];
   logic [AW-1:0]    slot_off_s [DEPTH];
   logic [DEPTH-1:0] live_s;
   logic [31:0]      mask_nxt_s;

   assign full_s    = (count_r == DEPTH_C);
   assign empty_s   = (count_r == {(AW+1){1'b0}});
   assign ready_s   = (count_r < DEPTH_C);
   assign memReady  = ready_s;
   assign aluReady  = ready_s;
   assign mem_acc_s = memValid & ready_s;
   assign alu_acc_s = aluValid & ready_s;
   assign alu_wr_s  = alu_acc_s & (aluReg != 5'd0);

`ifdef WB_BYPASS_EN
   // An idle block lets a load skip the FIFO entirely.
   assign bypass_s  = mem_acc_s & (memReg != 5'd0) & empty_s & ~alu_acc_s;
`else
   assign bypass_s  = 1'b0;
`endif

   // Loads to x0 are acknowledged but never stored.
   assign push_s    = mem_acc_s & (memReg != 5'd0) & ~bypass_s;

   // Write-source selection: full FIFO first, then ALU, then FIFO, then bypass.
   always_comb begin
      pop_s     = 1'b0;
      wr_en_s   = 1'b0;
      wr_reg_s  = writeReg;
      wr_data_s = writeData;
      if (full_s || (!alu_wr_s && !empty_s)) begin
         pop_s = 1'b1;
         if (!kill_r[rd_ptr_r]) begin
            wr_en_s   = 1'b1;
            wr_reg_s  = reg_mem_r[rd_ptr_r];
            wr_data_s = data_mem_r[rd_ptr_r];
         end else begin
            wr_en_s   = 1'b0;
         end
      end else if (alu_wr_s) begin
         wr_en_s   = 1'b1;
         wr_reg_s  = aluReg;
         wr_data_s = aluData;
      end else if (bypass_s) begin
         wr_en_s   = 1'b1;
         wr_reg_s  = memReg;
         wr_data_s = memData;
      end else begin
         wr_en_s   = 1'b0;
      end
   end

   // Kill bits after this edge; a load pushed alongside a matching ALU write
   // counts as older and is killed immediately.
   always_comb begin
      kill_nxt_s = kill_r;
      for (int i = 0; i < DEPTH; i++) begin
         if (alu_wr_s && (reg_mem_r[i] == aluReg)) begin
            kill_nxt_s[i] = 1'b1;
         end else begin
            kill_nxt_s[i] = kill_r[i];
         end
      end
      if (push_s) begin
         kill_nxt_s[wr_ptr_r] = alu_wr_s & (memReg == aluReg);
      end else begin
         kill_nxt_s[wr_ptr_r] = kill_nxt_s[wr_ptr_r];
      end
   end

   assign rd_nxt_s    = rd_ptr_r + AW'(pop_s);
   assign count_nxt_s = count_r + (AW+1)'(push_s) - (AW+1)'(pop_s);

   // Per-slot liveness in the post-update FIFO (offset from new head < count).
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         if (push_s && (wr_ptr_r == AW'(i))) begin
            slot_reg_s[i] = memReg;
         end else begin
            slot_reg_s[i] = reg_mem_r[i];
         end
         slot_off_s[i] = AW'(i) - rd_nxt_s;
         live_s[i]     = ({1'b0, slot_off_s[i]} < count_nxt_s) & ~kill_nxt_s[i];
      end
   end

   // Pending mask: OR of destination bits over live entries; x0 never pending.
   always_comb begin
      mask_nxt_s = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         if (live_s[i]) begin
            mask_nxt_s[slot_reg_s[i]] = 1'b1;
         end else begin
            mask_nxt_s = mask_nxt_s;
         end
      end
      mask_nxt_s[0] = 1'b0;
   end

   // FIFO storage, pointers, count and kill bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            reg_mem_r[i]  <= 5'd0;
            data_mem_r[i] <= 32'd0;
         end
         kill_r   <= {DEPTH{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         wr_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (push_s) begin
            reg_mem_r[wr_ptr_r]  <= memReg;
            data_mem_r[wr_ptr_r] <= memData;
            wr_ptr_r             <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         end
         kill_r   <= kill_nxt_s;
         rd_ptr_r <= rd_nxt_s;
         count_r  <= count_nxt_s;
      end
   end

   // Registered register-file write port and pending mask.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         writeEnable <= 1'b0;
         writeReg    <= 5'd0;
         writeData   <= 32'd0;
         pendingMask <= 32'd0;
      end else begin
         writeEnable <= wr_en_s;
         writeReg    <= wr_reg_s;
         writeData   <= wr_data_s;
         pendingMask <= mask_nxt_s;
      end
   end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Write-back stage directly upstream of the register file; sole driver of its writeData, writeReg and writeEnable inputs.
- Merges two result sources into at most one register write per cycle:
  - single-cycle ALU results;
  - variable-latency load results from the data-memory interface, buffered in a small FIFO.
- Resolves write-after-write ordering between the two sources.
- Exports a pending-write mask for the hazard unit.

Parameters:
- DEPTH, 4, load FIFO entries; power of two, at least 2.
- AW, 2, FIFO pointer width, equal to log2(DEPTH).

Ports:
- clk  in  1  processor clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- aluValid  in  1  ALU result present this cycle.
- aluReg  in  5  ALU destination register.
- aluData  in  32  ALU result.
- aluReady  out  1  ALU result accepted this cycle; combinational.
- memValid  in  1  load result present this cycle.
- memReg  in  5  load destination register.
- memData  in  32  load data.
- memReady  out  1  load result accepted this cycle; combinational.
- writeEnable  out  1  register-file write strobe; registered.
- writeReg  out  5  register-file destination; registered.
- writeData  out  32  register-file data; registered.
- pendingMask  out  32  bit r set while a live (non-killed) FIFO entry targets register r; registered.

Behaviour:
- Reset: already decided — one clock (clk); reset rst_n is asynchronous and active-low.
  - While rst_n=0: writeEnable=0, writeReg=0, writeData=0, pendingMask=0; FIFO empty, count=0; all kill bits clear.
  - Any queued loads are discarded.
- FIFO entry contents: reg[4:0], data[31:0], kill bit.
- Handshakes:
  - memReady = (count < DEPTH).
  - aluReady = (count < DEPTH).
  - A transfer occurs when valid and ready are both high at the rising edge.
- Load enqueue:
  - An accepted load with memReg≠0 is pushed into the FIFO.
  - An accepted load with memReg=0 is acknowledged and dropped.
- Write selection at each rising edge, in priority order:
  1. FIFO full (count=DEPTH): pop the head and write it. ALU is stalled via aluReady=0.
  2. Else, accepted ALU result with aluReg≠0: write it. FIFO head waits.
  3. Else, FIFO non-empty: pop the head and write it.
  4. Else: writeEnable=0; writeReg and writeData hold their values.
- Popped entries:
  - A popped entry with kill=1 is discarded; writeEnable=0 that cycle.
  - An accepted ALU result with aluReg=0 is consumed without a write.
- Latency:
  - ALU: write visible the cycle after acceptance (1 cycle).
  - Load: minimum 2 cycles (enqueue edge, then drain edge).
- WAW kill rule:
  - An accepted ALU write to register r≠0 sets kill on every FIFO entry with reg=r.
  - This includes a load enqueued on the same edge, which is treated as older.
- Simultaneous operations:
  - Push and pop on the same edge: count is unchanged.
  - Pointers wrap modulo DEPTH.
- pendingMask:
  - Recomputed each edge from the post-update FIFO contents.
  - Bit r = OR over live entries with reg=r. Bit 0 is always 0.
- x0 is never written: writeEnable=1 implies writeReg≠0.

Optional Feature:
- Macro: WB_BYPASS_EN.
- When defined: a load accepted while the FIFO is empty and no ALU result is accepted skips the FIFO. It is written on the same edge (latency 1, pendingMask unaffected).
- When undefined: all loads pass through the FIFO (minimum latency 2).

Test Plan:
- Reset: assert rst_n=0 mid-stream with 3 queued loads → outputs and pendingMask go to 0 immediately. After release, no queued write ever appears.
- ALU only: aluValid=1, aluReg=5, aluData=0xDEADBEEF → next cycle writeEnable=1, writeReg=5, writeData=0xDEADBEEF. With aluReg=0 → writeEnable stays 0.
- Priority: load memReg=7/0x11 and ALU aluReg=3/0x22 on the same edge → cycle+1 writes r3=0x22, cycle+2 writes r7=0x11. pendingMask bit7 set for exactly one cycle.
- WAW kill: load r9=0xAAAA queued, then ALU r9=0xBBBB → r9 written 0xBBBB. The later pop of the load gives writeEnable=0, and pendingMask bit9 clears.
- Full FIFO: DEPTH=4, four loads queued while ALU is busy → memReady=0 and aluReady=0. The next edge drains the head, and both ready signals return to 1.
- Bypass (WB_BYPASS_EN defined): single load r4=0x1234 into an idle block → write on the next edge (latency 1). Undefined → latency 2.
